version_store: RTL and testbench

- Upstream neighbour of the priority router. Holds VERSION_NUM versioned copies of one data word and presents them as flattened buses that the router consumes directly.
- Each accepted write gets the next version number and lands in a free or evictable slot.
- Slots still visible to the oldest active reader are never overwritten. Writes stall until a slot can be reclaimed.

---
 rtl/version_store.sv | 145 ++++++++++++++
 tb/tb_version_store.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/version_store.sv
// version_store
//   Keeps VERSION_NUM versioned copies of one data word for the priority
//   router downstream. Each accepted write takes the next version number
//   (modulo 2^VERSION_WIDTH). It lands in the lowest free slot, or else in
//   the oldest slot that no active reader can still request. When no slot
//   can be reclaimed, writes stall.
//
// Ports
//   clk           clock
//   rstN          asynchronous active-low reset
//   wrValid       write request
//   wrReady       write accepted on a clk edge when wrValid && wrReady
//   wrData        write payload
//   oldestReader  oldest version any reader may still request
//   wrDone        one-cycle pulse when a write commits
//   wrVersion     version given to the committed write (valid with wrDone)
//   curVersion    newest committed version
//   slotData      flattened slot payloads, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   slotVersions  flattened slot tags, slot i at [i*VERSION_WIDTH +: VERSION_WIDTH]
//   slotValid     bit i set when slot i holds a committed version
module version_store #(
  parameter int DATA_WIDTH    = 32,
  parameter int VERSION_WIDTH = 4,
  parameter int VERSION_NUM   = 4
) (
  input  logic                                 clk,
  input  logic                                 rstN,
  input  logic                                 wrValid,
  output logic                                 wrReady,
  input  logic [DATA_WIDTH-1:0]                wrData,
  input  logic [VERSION_WIDTH-1:0]             oldestReader,
  output logic                                 wrDone,
  output logic [VERSION_WIDTH-1:0]             wrVersion,
  output logic [VERSION_WIDTH-1:0]             curVersion,
  output logic [DATA_WIDTH*VERSION_NUM-1:0]    slotData,
  output logic [VERSION_WIDTH*VERSION_NUM-1:0] slotVersions,
  output logic [VERSION_NUM-1:0]               slotValid
);

  localparam int IDX_W = (VERSION_NUM > 1) ? $clog2(VERSION_NUM) : 1;

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t                   state;
  logic [DATA_WIDTH-1:0]    slotDataR [VERSION_NUM];
  logic [VERSION_WIDTH-1:0] slotVerR  [VERSION_NUM];
  logic [VERSION_NUM-1:0]   slotValidR;
  logic [VERSION_WIDTH-1:0] curVer;
  logic [DATA_WIDTH-1:0]    latchData;
  logic [IDX_W-1:0]         latchIdx;

  logic [VERSION_WIDTH-1:0] nextVer;
  logic [VERSION_WIDTH-1:0] readerAge;
  logic [VERSION_WIDTH-1:0] age;
  logic [VERSION_WIDTH-1:0] bestAge;
  logic                     haveInvalid;
  logic [IDX_W-1:0]         invIdx;
  logic                     evFound;
  logic [IDX_W-1:0]         evIdx;
  logic                     victimFound;
  logic [IDX_W-1:0]         victimIdx;

  assign nextVer = curVer + VERSION_WIDTH'(1);

  // Victim selection. Ages are modular distances back from curVer, so the
  // ordering survives counter wrap. A slot is reclaimable only when it is
  // strictly older than the oldest reader. Because readerAge is never
  // negative, this also rules out the current version (age 0).
  always_comb begin
    readerAge   = curVer - oldestReader;
    age         = '0;
    bestAge     = '0;
    haveInvalid = 1'b0;
    invIdx      = '0;
    evFound     = 1'b0;
    evIdx       = '0;
    for (int i = 0; i < VERSION_NUM; i++) begin
      if (!slotValidR[i] && !haveInvalid) begin
        haveInvalid = 1'b1;
        invIdx      = IDX_W'(i);
      end
    end
    for (int i = 0; i < VERSION_NUM; i++) begin
      age = curVer - slotVerR[i];
      // Strict '>' on bestAge keeps ties on the lowest index.
      if (slotValidR[i] && (age > readerAge) && (!evFound || (age > bestAge))) begin
        evFound = 1'b1;
        bestAge = age;
        evIdx   = IDX_W'(i);
      end
    end
    victimFound = haveInvalid || evFound;
    victimIdx   = haveInvalid ? invIdx : evIdx;
  end

  assign wrReady = (state == IDLE) && victimFound;

  // Write FSM: IDLE latches the request and the victim. COMMIT writes the
  // slot and publishes the new version.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      slotValidR <= VERSION_NUM'(1);
      for (int i = 0; i < VERSION_NUM; i++) begin
        slotDataR[i] <= '0;
        slotVerR[i]  <= '0;
      end
      curVer    <= '0;
      wrDone    <= 1'b0;
      wrVersion <= '0;
      latchData <= '0;
      latchIdx  <= '0;
    end else begin
      wrDone <= 1'b0;
      case (state)
        IDLE: begin
          if (wrValid && wrReady) begin
            latchData <= wrData;
            latchIdx  <= victimIdx;
            state     <= COMMIT;
          end
        end
        COMMIT: begin
          slotDataR[latchIdx]  <= latchData;
          slotVerR[latchIdx]   <= nextVer;
          slotValidR[latchIdx] <= 1'b1;
          curVer               <= nextVer;
          wrVersion            <= nextVer;
          wrDone               <= 1'b1;
          state                <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign curVersion = curVer;
  assign slotValid  = slotValidR;

  for (genvar g = 0; g < VERSION_NUM; g++) begin : gFlat
    assign slotData[g*DATA_WIDTH +: DATA_WIDTH]          = slotDataR[g];
    assign slotVersions[g*VERSION_WIDTH +: VERSION_WIDTH] = slotVerR[g];
  end

endmodule

// File: tb/tb_version_store.sv
module tb_version_store;
  localparam int DW = 32;
  localparam int VW = 4;
  localparam int VN = 4;

  logic              clk = 1'b0;
  logic              rstN;
  logic              wrValid;
  logic              wrReady;
  logic [DW-1:0]     wrData;
  logic [VW-1:0]     oldestReader;
  logic              wrDone;
  logic [VW-1:0]     wrVersion;
  logic [VW-1:0]     curVersion;
  logic [DW*VN-1:0]  slotData;
  logic [VW*VN-1:0]  slotVersions;
  logic [VN-1:0]     slotValid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  version_store #(.DATA_WIDTH(DW), .VERSION_WIDTH(VW), .VERSION_NUM(VN)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .wrValid      (wrValid),
    .wrReady      (wrReady),
    .wrData       (wrData),
    .oldestReader (oldestReader),
    .wrDone       (wrDone),
    .wrVersion    (wrVersion),
    .curVersion   (curVersion),
    .slotData     (slotData),
    .slotVersions (slotVersions),
    .slotValid    (slotValid)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One write: ready on entry, busy for one cycle, then the commit is visible.
  // wrValid is left high so consecutive calls are back-to-back.
  task automatic doWrite(input logic [DW-1:0] d, input logic [VW-1:0] v,
                         input int s, input string tag);
    logic [VW-1:0] prev;
    prev    = v - VW'(1);
    wrData  = d;
    wrValid = 1'b1;
    #1;
    check({tag, ".ready"}, wrReady, 1'b1);
    tick;
    check({tag, ".busyReady"}, wrReady, 1'b0);
    check({tag, ".busyDone"}, wrDone, 1'b0);
    check({tag, ".busyCur"}, curVersion, prev);
    tick;
    check({tag, ".done"}, wrDone, 1'b1);
    check({tag, ".wrVersion"}, wrVersion, v);
    check({tag, ".cur"}, curVersion, v);
    check({tag, ".slotVer"}, slotVersions[s*VW +: VW], v);
    check({tag, ".slotData"}, slotData[s*DW +: DW], d);
    check({tag, ".slotValid"}, slotValid[s], 1'b1);
  endtask

  initial begin
    logic [VW-1:0] v;

    // Reset
    rstN = 1'b0; wrValid = 1'b0; wrData = '0; oldestReader = '0;
    tick; tick;
    rstN = 1'b1;
    #1;
    check("reset.slotValid", slotValid, 4'b0001);
    check("reset.cur", curVersion, 0);
    check("reset.ready", wrReady, 1'b1);
    check("reset.done", wrDone, 1'b0);
    check("reset.data", slotData, 0);
    check("reset.vers", slotVersions, 0);

    // Fill the three free slots back-to-back
    doWrite(32'hA, 4'd1, 1, "fillA");
    doWrite(32'hB, 4'd2, 2, "fillB");
    doWrite(32'hC, 4'd3, 3, "fillC");
    check("fill.slotValid", slotValid, 4'b1111);
    check("fill.slot0Ver", slotVersions[0 +: VW], 0);

    // Stall: every slot is still visible to reader 0
    wrData = 32'hD;
    #1;
    check("stall.ready0", wrReady, 1'b0);
    tick;
    check("stall.ready1", wrReady, 1'b0);
    check("stall.done", wrDone, 1'b0);
    tick;
    check("stall.cur", curVersion, 3);
    oldestReader = 4'd1;
    doWrite(32'hD, 4'd4, 0, "release");

    // Oldest-first eviction with reader at 4
    oldestReader = 4'd4;
    doWrite(32'h11, 4'd5, 1, "evict1");
    doWrite(32'h22, 4'd6, 2, "evict2");
    doWrite(32'h33, 4'd7, 3, "evict3");
    wrValid = 1'b0;
    #1;
    check("evict.slot0Ver", slotVersions[0 +: VW], 4);
    check("evict.slot0Data", slotData[0 +: DW], 32'hD);
    check("evict.stallReady", wrReady, 1'b0);
    oldestReader = 4'd5;
    #1;
    check("evict.advanceReady", wrReady, 1'b1);

    // Wrap: reader tracks the newest version, eviction rotates through slots
    for (int k = 0; k < 12; k++) begin
      v = VW'(8 + k);
      oldestReader = curVersion;
      doWrite(32'h100 + DW'(k), v, int'(v) % VN, $sformatf("wrap%0d", k));
    end
    wrValid = 1'b0;
    #1;
    check("wrap.cur", curVersion, 3);
    check("wrap.vers", slotVersions, 16'h3210);

    // Reset during COMMIT discards the write
    oldestReader = curVersion;
    wrData  = 32'hE;
    wrValid = 1'b1;
    #1;
    check("midrst.ready", wrReady, 1'b1);
    tick;
    check("midrst.busy", wrReady, 1'b0);
    rstN = 1'b0;
    #1;
    check("midrst.slotValid", slotValid, 4'b0001);
    check("midrst.cur", curVersion, 0);
    check("midrst.done", wrDone, 1'b0);
    check("midrst.data", slotData, 0);
    check("midrst.vers", slotVersions, 0);
    wrValid = 1'b0;
    tick;
    check("midrst.doneEdge", wrDone, 1'b0);
    check("midrst.wrVersion", wrVersion, 0);
    rstN = 1'b1;
    oldestReader = '0;
    doWrite(32'hF, 4'd1, 1, "postrst");
    wrValid = 1'b0;
    tick;
    check("postrst.pulseEnd", wrDone, 1'b0);
    check("postrst.slotValid", slotValid, 4'b0011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
